// File: rtl/riscv_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Generates per-stage hold and bubble controls for load-use hazards,
// taken branches, traps, data-memory wait states and multi-cycle mul/div.
//
//   state | meaning
//   RUN   | normal issue; a mul/div entering EX may start an occupancy window
//   MDIV  | mul/div occupying EX; cnt counts the stall cycles still to go
//
// Outputs are combinational so stalls and clears act on the current edge.
module riscv_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic       i_ex_valid,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_load,
    input  logic       i_ex_muldiv,
    input  logic       i_ex_branch_taken,
    input  logic       i_mem_busy,
    input  logic       i_trap,
    output logic       o_stall_if,
    output logic       o_stall_id,
    output logic       o_stall_ex,
    output logic       o_stall_mem,
    output logic       o_clr_id,
    output logic       o_clr_ex,
    output logic       o_clr_mem,
    output logic       o_clr_wb,
    output logic       o_muldiv_done
);

    typedef enum logic {RUN = 1'b0, MDIV = 1'b1} state_t;

    // A single-cycle mul/div never enters MDIV; otherwise the first stall
    // cycle happens in RUN, leaving MULDIV_CYCLES-2 more to count in MDIV.
    localparam bit MD_MULTI = (MULDIV_CYCLES > 1);
    localparam int MD_LOAD_I = MD_MULTI ? (MULDIV_CYCLES - 2) : 0;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LOAD_I);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic ld_hz;
    logic md_start;
    logic md_hold;
    logic md_last;
    logic md_single;
    logic br_flush;

    // Hazard and mul/div qualifiers shared by output and next-state logic
    always_comb begin
        ld_hz     = i_ex_valid && i_ex_load && (i_ex_rd != 5'd0) &&
                    ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                     (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));
        md_start  = (state == RUN) && i_ex_valid && i_ex_muldiv && MD_MULTI;
        md_single = (state == RUN) && i_ex_valid && i_ex_muldiv && !MD_MULTI;
        md_hold   = md_start || ((state == MDIV) && (cnt != '0));
        md_last   = (state == MDIV) && (cnt == '0);
        br_flush  = i_ex_branch_taken && i_ex_valid;
    end

    // Prioritised stall/clear decode; everything is held low during reset
    always_comb begin
        o_stall_if    = 1'b0;
        o_stall_id    = 1'b0;
        o_stall_ex    = 1'b0;
        o_stall_mem   = 1'b0;
        o_clr_id      = 1'b0;
        o_clr_ex      = 1'b0;
        o_clr_mem     = 1'b0;
        o_clr_wb      = 1'b0;
        o_muldiv_done = 1'b0;
        if (!i_rstn) begin
            o_stall_if = 1'b0;
        end else if (i_trap) begin
            o_clr_id  = 1'b1;
            o_clr_ex  = 1'b1;
            o_clr_mem = 1'b1;
        end else if (i_mem_busy) begin
            o_stall_if  = 1'b1;
            o_stall_id  = 1'b1;
            o_stall_ex  = 1'b1;
            o_stall_mem = 1'b1;
            o_clr_wb    = 1'b1;
        end else if (md_hold) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_stall_ex = 1'b1;
            o_clr_mem  = 1'b1;
        end else begin
            // Completion does not block the branch / load-use rows below it
            o_muldiv_done = md_last || md_single;
            if (br_flush) begin
                // ID holds a wrong-path instruction, so its load-use stall is moot
                o_clr_id = 1'b1;
                o_clr_ex = 1'b1;
            end else if (ld_hz) begin
                o_stall_if = 1'b1;
                o_stall_id = 1'b1;
                o_clr_ex   = 1'b1;
            end
        end
    end

    // Next-state: trap aborts, memory wait freezes, otherwise count down
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (i_trap) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else if (i_mem_busy) begin
            state_nxt = state;
        end else if (md_start) begin
            state_nxt = MDIV;
            cnt_nxt   = MD_LOAD;
        end else if ((state == MDIV) && (cnt != '0)) begin
            cnt_nxt = cnt - 1'b1;
        end else if (state == MDIV) begin
            state_nxt = RUN;
        end
    end

    // State and counter registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl. Two instances share the inputs:
// dut (MULDIV_CYCLES=4) and dut1 (MULDIV_CYCLES=1). Each stimulus cycle
// pushes hand-computed outputs for both; a monitor pops and compares on
// the falling edge.
module tb_riscv_hazard_ctrl;

    logic       i_clk;
    logic       i_rstn;
    logic [4:0] i_id_rs1;
    logic [4:0] i_id_rs2;
    logic       i_id_rs1_used;
    logic       i_id_rs2_used;
    logic       i_ex_valid;
    logic [4:0] i_ex_rd;
    logic       i_ex_load;
    logic       i_ex_muldiv;
    logic       i_ex_branch_taken;
    logic       i_mem_busy;
    logic       i_trap;

    logic s_if4, s_id4, s_ex4, s_mem4, c_id4, c_ex4, c_mem4, c_wb4, done4;
    logic s_if1, s_id1, s_ex1, s_mem1, c_id1, c_ex1, c_mem1, c_wb1, done1;

    // {stall_if, stall_id, stall_ex, stall_mem, clr_id, clr_ex, clr_mem, clr_wb, done}
    localparam logic [8:0] NONE = 9'h000;
    localparam logic [8:0] LDHZ = 9'h188;
    localparam logic [8:0] BR   = 9'h018;
    localparam logic [8:0] MDH  = 9'h1C4;
    localparam logic [8:0] DONE = 9'h001;
    localparam logic [8:0] BUSY = 9'h1E2;
    localparam logic [8:0] TRAP = 9'h01C;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic       valid;
        logic [4:0] rd;
        logic       load;
        logic       muldiv;
        logic       br;
        logic       busy;
        logic       trap;
    } in_t;

    typedef struct {
        logic [8:0] e4;
        logic [8:0] e1;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    riscv_hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(4)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_valid(i_ex_valid), .i_ex_rd(i_ex_rd), .i_ex_load(i_ex_load),
        .i_ex_muldiv(i_ex_muldiv), .i_ex_branch_taken(i_ex_branch_taken),
        .i_mem_busy(i_mem_busy), .i_trap(i_trap),
        .o_stall_if(s_if4), .o_stall_id(s_id4), .o_stall_ex(s_ex4),
        .o_stall_mem(s_mem4), .o_clr_id(c_id4), .o_clr_ex(c_ex4),
        .o_clr_mem(c_mem4), .o_clr_wb(c_wb4), .o_muldiv_done(done4)
    );

    riscv_hazard_ctrl #(.MULDIV_CYCLES(1), .CNT_W(4)) dut1 (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_valid(i_ex_valid), .i_ex_rd(i_ex_rd), .i_ex_load(i_ex_load),
        .i_ex_muldiv(i_ex_muldiv), .i_ex_branch_taken(i_ex_branch_taken),
        .i_mem_busy(i_mem_busy), .i_trap(i_trap),
        .o_stall_if(s_if1), .o_stall_id(s_id1), .o_stall_ex(s_ex1),
        .o_stall_mem(s_mem1), .o_clr_id(c_id1), .o_clr_ex(c_ex1),
        .o_clr_mem(c_mem1), .o_clr_wb(c_wb1), .o_muldiv_done(done1)
    );

    logic [8:0] out4;
    logic [8:0] out1;
    assign out4 = {s_if4, s_id4, s_ex4, s_mem4, c_id4, c_ex4, c_mem4, c_wb4, done4};
    assign out1 = {s_if1, s_id1, s_ex1, s_mem1, c_id1, c_ex1, c_mem1, c_wb1, done1};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Monitor: compare both instances against the oldest pending expectation
    always @(negedge i_clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s (md4): got %03h expected %03h", e.name, out4, e.e4);
            end
            n_tests++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s (md1): got %03h expected %03h", e.name, out1, e.e1);
            end
        end
    end

    task automatic apply(input in_t v);
        i_id_rs1          = v.rs1;
        i_id_rs2          = v.rs2;
        i_id_rs1_used     = v.rs1_used;
        i_id_rs2_used     = v.rs2_used;
        i_ex_valid        = v.valid;
        i_ex_rd           = v.rd;
        i_ex_load         = v.load;
        i_ex_muldiv       = v.muldiv;
        i_ex_branch_taken = v.br;
        i_mem_busy        = v.busy;
        i_trap            = v.trap;
    endtask

    task automatic step(input string name, input in_t v,
                        input logic [8:0] e4, input logic [8:0] e1);
        exp_t e;
        @(posedge i_clk);
        #1;
        apply(v);
        e.e4 = e4; e.e1 = e1; e.name = name;
        q.push_back(e);
    endtask

    // Reset pulse inside one cycle: asserted after an edge, released before the next
    task automatic rst_step(input string name, input in_t v);
        exp_t e;
        @(posedge i_clk);
        #1;
        apply(v);
        i_rstn = 1'b0;
        e.e4 = NONE; e.e1 = NONE; e.name = name;
        q.push_back(e);
        @(negedge i_clk);
        #1;
        apply('0);
        i_rstn = 1'b1;
    endtask

    function automatic in_t ld(input logic [4:0] rd, input logic [4:0] rs1,
                               input logic u1, input logic [4:0] rs2, input logic u2);
        in_t v;
        v = '0;
        v.valid = 1'b1; v.load = 1'b1; v.rd = rd;
        v.rs1 = rs1; v.rs1_used = u1; v.rs2 = rs2; v.rs2_used = u2;
        return v;
    endfunction

    function automatic in_t md();
        in_t v;
        v = '0;
        v.valid = 1'b1; v.muldiv = 1'b1;
        return v;
    endfunction

    initial begin
        in_t v;
        exp_t e;
        i_rstn = 1'b0;
        apply(md());
        e.e4 = NONE; e.e1 = NONE; e.name = "reset_outputs";
        q.push_back(e);
        @(negedge i_clk);
        #1;
        apply('0);
        i_rstn = 1'b1;

        step("idle", '0, NONE, NONE);

        // Load-use
        step("ld_rs2", ld(5'd5, 5'd1, 1'b1, 5'd5, 1'b1), LDHZ, LDHZ);
        step("ld_gone", '0, NONE, NONE);
        step("ld_rd0", ld(5'd0, 5'd0, 1'b1, 5'd0, 1'b1), NONE, NONE);
        step("ld_rs1", ld(5'd7, 5'd7, 1'b1, 5'd3, 1'b1), LDHZ, LDHZ);
        step("ld_rs1_unused", ld(5'd7, 5'd7, 1'b0, 5'd3, 1'b1), NONE, NONE);
        v = ld(5'd9, 5'd9, 1'b1, 5'd9, 1'b1); v.valid = 1'b0;
        step("ld_invalid", v, NONE, NONE);

        // Branch vs load-use
        v = ld(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); v.br = 1'b1;
        step("br_over_ld", v, BR, BR);
        v = '0; v.valid = 1'b1; v.br = 1'b1;
        step("br_only", v, BR, BR);
        v.valid = 1'b0;
        step("br_invalid", v, NONE, NONE);

        // Mul/div occupancy with back-to-back ops
        step("md_t0", md(), MDH, DONE);
        step("md_t1", md(), MDH, DONE);
        step("md_t2", md(), MDH, DONE);
        step("md_t3_done", md(), DONE, DONE);
        step("md2_t4", md(), MDH, DONE);
        step("md2_t5", md(), MDH, DONE);
        step("md2_t6", md(), MDH, DONE);
        step("md2_t7_done", md(), DONE, DONE);
        step("md_after", '0, NONE, NONE);

        // Memory wait inside mul/div freezes the counter
        step("mb_t0", md(), MDH, DONE);
        v = md(); v.busy = 1'b1;
        step("mb_t1_busy", v, BUSY, BUSY);
        step("mb_t2_busy", v, BUSY, BUSY);
        step("mb_t3", md(), MDH, DONE);
        step("mb_t4", md(), MDH, DONE);
        v = md(); v.load = 1'b1; v.rd = 5'd5; v.rs2 = 5'd5; v.rs2_used = 1'b1;
        step("mb_t5_done_ld", v, DONE | LDHZ, DONE | LDHZ);
        step("mb_after", '0, NONE, NONE);
        v = ld(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); v.busy = 1'b1;
        step("busy_over_ld", v, BUSY, BUSY);

        // Trap aborts mul/div
        step("tr_t0", md(), MDH, DONE);
        v = md(); v.trap = 1'b1;
        step("tr_t1_trap", v, TRAP, TRAP);
        step("tr_after", '0, NONE, NONE);
        v = '0; v.trap = 1'b1; v.busy = 1'b1;
        step("trap_over_busy", v, TRAP, TRAP);

        // Asynchronous reset in the middle of MDIV
        step("rs_t0", md(), MDH, DONE);
        step("rs_t1", md(), MDH, DONE);
        rst_step("rs_async", md());
        step("rs_after", '0, NONE, NONE);
        step("rs_md_t0", md(), MDH, DONE);
        step("rs_md_t1", md(), MDH, DONE);
        step("rs_md_t2", md(), MDH, DONE);
        step("rs_md_t3_done", md(), DONE, DONE);
        step("rs_end", '0, NONE, NONE);

        @(posedge i_clk);
        @(posedge i_clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
